lsu_rmw: RTL
============

// Module: lsu_rmw
// PURPOSE
//  Load/store unit between the core's memory stage and data_mem (32-bit word RAM; 1-cycle sync read; no byte enables).
//  Turns byte/half/word loads/stores into word accesses: sign/zero-extends loads; sub-word stores via read-modify-write.
//  Stalls the core while a multi-cycle access is in flight; flags misaligned/illegal accesses.
// PARAMETERS
//  DATA_W  32  data width; only 32 supported
//  ADDR_W  32  byte address width
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  rst_ni         in   1       reset, synchronous, active-low
//  core_req_i     in   1       access request; held with all core_* inputs until core_stall_o low
//  core_we_i      in   1       1 = store, 0 = load
//  core_size_i    in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  core_addr_i    in   ADDR_W  byte address
//  core_wd_i      in   DATA_W  store data, right-aligned
//  core_rd_o      out  DATA_W  load result, valid in LOAD_RESP only, else 0
//  core_stall_o   out  1       1 = core must hold request
//  core_exc_o     out  1       misaligned or illegal size, 1-cycle pulse
//  mem_req_o      out  1       to data_mem mem_req_i
//  mem_we_o       out  1       to data_mem write_enable_i
//  mem_addr_o     out  ADDR_W  {core_addr_i[31:2],2'b00}
//  mem_wd_o       out  DATA_W  to data_mem write_data_i
//  mem_rd_i       in   DATA_W  from data_mem read_data_o (valid 1 cycle after read req)
// BEHAVIOUR
//  States: IDLE, LOAD_RESP, RMW_WRITE. Reset -> IDLE; all outputs 0 while rst_ni=0 (mem_req_o forced 0).
//  Outputs combinational from state + core inputs; offset addr[1:0] and size registered at issue.
//  IDLE, no req: all outputs 0.
//  IDLE, exception (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0; size 011/11x; store 100/101):
//   core_exc_o=1, mem_req_o=0, stall=0, stay IDLE.
//  IDLE, load: mem_req_o=1, mem_we_o=0, stall=1 -> LOAD_RESP.
//  LOAD_RESP: mem_req_o=0, stall=0; core_rd_o = selected byte/half of mem_rd_i at reg offset,
//   sign-ext (B,H) or zero-ext (BU,HU), W passthrough -> IDLE. Load latency 2 cycles total.
//  IDLE, SW: mem_req_o=1, mem_we_o=1, mem_wd_o=core_wd_i, stall=0, stay IDLE. 1 cycle.
//  IDLE, SB/SH: read issued (mem_req_o=1, mem_we_o=0), stall=1 -> RMW_WRITE.
//  RMW_WRITE: mem_req_o=1, mem_we_o=1, mem_wd_o = mem_rd_i with lane(s) at reg offset replaced by
//   core_wd_i[7:0]/[15:0]; stall=0 -> IDLE. 2 cycles total.
//  core_req_i seen in LOAD_RESP/RMW_WRITE is same held instruction; not re-issued.
//  Back-to-back: new request accepted only in IDLE; next access issues cycle after return to IDLE.
//  rst_ni low in LOAD_RESP/RMW_WRITE: no write issued that cycle, state -> IDLE, no partial store.
//  Address wrap: mem_addr_o bits above data_mem depth passed through unchanged (memory aliases).
// TESTING
//  Preload mem[0x10]=0x8899AABB for all cases.
//  LB 0x13 -> stall 1 cycle, core_rd_o=0xFFFFFF88; LBU 0x13 -> 0x00000088.
//  LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB; LW 0x10 -> 0x8899AABB.
//  SB 0x11 wd=0x000000CC -> read cycle, then write mem_wd_o=0x8899CCBB; readback LW=0x8899CCBB.
//  SW 0x10 wd=0x12345678 -> single cycle, stall never 1, mem_we_o=1; SH 0x12 wd=0xBEEF -> 0xBEEFAABB.
//  LW 0x12 / SH 0x11 / size=011 -> core_exc_o=1, mem_req_o=0, memory unchanged.
//  SB 0x10 then rst_ni=0 in RMW_WRITE -> mem_we_o=0 that cycle, state IDLE, mem[0x10] unchanged.

Source files
------------

// File: rtl/lsu_rmw.sv
// Load/store unit: maps byte/half/word core accesses onto a word-only data RAM,
// extending loads and merging sub-word stores with a read-modify-write.
module lsu_rmw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              core_exc_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_RESP = 2'd1,
        RMW_WRITE = 2'd2
    } state_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  size_q, size_d;

    logic              illegal_size;
    logic              misaligned;
    logic              req_exc;
    logic [ADDR_W-1:0] word_addr;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] store_lane;
    logic [DATA_W-1:0] merged;

    assign word_addr = {core_addr_i[ADDR_W-1:2], 2'b00};

    // Unsigned sizes are load-only; 011 and 11x are never legal.
    always_comb begin
        illegal_size = 1'b1;
        case (core_size_i)
            SZ_B, SZ_H, SZ_W: illegal_size = 1'b0;
            SZ_BU, SZ_HU:     illegal_size = core_we_i;
            default:          illegal_size = 1'b1;
        endcase
        misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                     ((core_size_i == SZ_W) && (core_addr_i[1:0] != 2'b00));
        req_exc = illegal_size || misaligned;
    end

    always_comb begin
        shamt      = {off_q, 3'b000};
        lane       = mem_rd_i >> shamt;
        load_ext   = mem_rd_i;
        lane_mask  = {{(DATA_W-8){1'b0}}, 8'hFF};
        store_lane = {{(DATA_W-8){1'b0}}, core_wd_i[7:0]};
        case (size_q)
            SZ_B:    load_ext = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            SZ_BU:   load_ext = {{(DATA_W-8){1'b0}}, lane[7:0]};
            SZ_H:    load_ext = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            SZ_HU:   load_ext = {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: load_ext = mem_rd_i;
        endcase
        if (size_q[0]) begin
            lane_mask  = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            store_lane = {{(DATA_W-16){1'b0}}, core_wd_i[15:0]};
        end
        merged = (mem_rd_i & ~(lane_mask << shamt)) | (store_lane << shamt);
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        core_rd_o    = '0;
        core_stall_o = 1'b0;
        core_exc_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wd_o     = '0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (req_exc) begin
                        core_exc_o = 1'b1;
                    end else begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = word_addr;
                        off_d      = core_addr_i[1:0];
                        size_d     = core_size_i;
                        if (!core_we_i) begin
                            core_stall_o = 1'b1;
                            state_d      = LOAD_RESP;
                        end else if (core_size_i == SZ_W) begin
                            mem_we_o = 1'b1;
                            mem_wd_o = core_wd_i;
                        end else begin
                            core_stall_o = 1'b1;
                            state_d      = RMW_WRITE;
                        end
                    end
                end
            end
            LOAD_RESP: begin
                core_rd_o = load_ext;
                state_d   = IDLE;
            end
            RMW_WRITE: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = word_addr;
                mem_wd_o   = merged;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset must suppress the pending RMW write so no partial store lands.
        if (!rst_ni) begin
            state_d      = IDLE;
            core_rd_o    = '0;
            core_stall_o = 1'b0;
            core_exc_o   = 1'b0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            mem_addr_o   = '0;
            mem_wd_o     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            off_q   <= 2'b00;
            size_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
        end
    end

endmodule
